int_rsv_station: RTL

Reservation station feeding the integer execution unit. Accepts dispatched integer ops with operands either present as values or pending on a producer tag, snoops the common data bus (CDB) to capture pending operands, and issues ready ops through a registered valid/ready output slot. Its output fields match the integer unit's input:

- opcode
- destination tag
- two flattened signed operands, V[0] in the low word.

---
 rtl/int_rsv_station_if.sv | 41 ++++
 rtl/int_rsv_station.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/int_rsv_station_if.sv
// Dispatch, CDB snoop and issue-slot signals of the integer reservation station.
// slave = station side, master = dispatcher / CDB / integer-unit side.
interface int_rsv_station_if #(
   parameter int BW_PROCESSOR_DATA = 32,
   parameter int BW_OPCODE_INT     = 3,
   parameter int BW_TAG            = 4
);
   logic                           i_dsp_valid;
   logic                           i_dsp_ready;
   logic [BW_OPCODE_INT-1:0]       i_dsp_opcode;
   logic [BW_TAG-1:0]              i_dsp_tag;
   logic [1:0]                     i_dsp_rdy;
   logic [2*BW_TAG-1:0]            i_dsp_Q_flatten;
   logic [2*BW_PROCESSOR_DATA-1:0] i_dsp_V_flatten;

   logic                           i_cdb_valid;
   logic [BW_TAG-1:0]              i_cdb_tag;
   logic [BW_PROCESSOR_DATA-1:0]   i_cdb_wdata;

   logic                           o_alu_valid;
   logic                           o_alu_ready;
   logic [BW_OPCODE_INT-1:0]       o_alu_opcode;
   logic [BW_TAG-1:0]              o_alu_tag;
   logic [2*BW_PROCESSOR_DATA-1:0] o_alu_V_flatten;

   modport slave (
      input  i_dsp_valid, i_dsp_opcode, i_dsp_tag, i_dsp_rdy, i_dsp_Q_flatten, i_dsp_V_flatten,
      output i_dsp_ready,
      input  i_cdb_valid, i_cdb_tag, i_cdb_wdata,
      output o_alu_valid, o_alu_opcode, o_alu_tag, o_alu_V_flatten,
      input  o_alu_ready
   );

   modport master (
      output i_dsp_valid, i_dsp_opcode, i_dsp_tag, i_dsp_rdy, i_dsp_Q_flatten, i_dsp_V_flatten,
      input  i_dsp_ready,
      output i_cdb_valid, i_cdb_tag, i_cdb_wdata,
      input  o_alu_valid, o_alu_opcode, o_alu_tag, o_alu_V_flatten,
      output o_alu_ready
   );
endinterface

// File: rtl/int_rsv_station.sv
// Integer reservation station: holds dispatched ops until both operands are captured
// (from dispatch or CDB snoop) and issues the lowest-index ready op through a registered slot.
module int_rsv_station #(
   parameter int BW_PROCESSOR_DATA = 32,
   parameter int BW_OPCODE_INT     = 3,
   parameter int BW_TAG            = 4,
   parameter int N_ENTRY           = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   int_rsv_station_if.slave     bus
);
   localparam int BW = BW_PROCESSOR_DATA;

   logic [N_ENTRY-1:0]                          r_busy;
   logic [N_ENTRY-1:0][BW_OPCODE_INT-1:0]       r_op;
   logic [N_ENTRY-1:0][BW_TAG-1:0]              r_tag;
   logic [N_ENTRY-1:0][1:0]                     r_rdy;
   logic [N_ENTRY-1:0][1:0][BW_TAG-1:0]         r_q;
   logic [N_ENTRY-1:0][1:0][BW-1:0]             r_v;

   logic                                        r_alu_valid;
   logic [BW_OPCODE_INT-1:0]                    r_alu_op;
   logic [BW_TAG-1:0]                           r_alu_tag;
   logic [2*BW-1:0]                             r_alu_v;

   logic [N_ENTRY-1:0]                          w_free;
   logic [N_ENTRY-1:0]                          w_free_oh;
   logic [N_ENTRY-1:0]                          w_elig;
   logic [N_ENTRY-1:0]                          w_elig_oh;
   logic                                        w_dsp_fire;
   logic                                        w_load;

   logic [1:0]                                  w_dsp_rdy;
   logic [1:0][BW_TAG-1:0]                      w_dsp_q;
   logic [1:0][BW-1:0]                          w_dsp_v;

   logic [BW_OPCODE_INT-1:0]                    w_sel_op;
   logic [BW_TAG-1:0]                           w_sel_tag;
   logic [2*BW-1:0]                             w_sel_v;

   // Lowest set bit isolation gives one-hot priority toward entry 0.
   assign w_free    = ~r_busy;
   assign w_free_oh = w_free & (~w_free + N_ENTRY'(1));

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         w_elig[i] = r_busy[i] & r_rdy[i][0] & r_rdy[i][1];
      end
   end

   assign w_elig_oh  = w_elig & (~w_elig + N_ENTRY'(1));
   assign w_dsp_fire = bus.i_dsp_valid & (|w_free);
   assign w_load     = (|w_elig) & (~r_alu_valid | bus.o_alu_ready);

   // Dispatched operands still pending may be satisfied by this cycle's broadcast.
   always_comb begin
      w_dsp_rdy = '0;
      w_dsp_q   = '0;
      w_dsp_v   = '0;
      for (int k = 0; k < 2; k++) begin
         w_dsp_q[k] = bus.i_dsp_Q_flatten[k*BW_TAG +: BW_TAG];
         if (!bus.i_dsp_rdy[k] && bus.i_cdb_valid && (w_dsp_q[k] == bus.i_cdb_tag)) begin
            w_dsp_rdy[k] = 1'b1;
            w_dsp_v[k]   = bus.i_cdb_wdata;
         end else begin
            w_dsp_rdy[k] = bus.i_dsp_rdy[k];
            w_dsp_v[k]   = bus.i_dsp_V_flatten[k*BW +: BW];
         end
      end
   end

   always_comb begin
      w_sel_op  = '0;
      w_sel_tag = '0;
      w_sel_v   = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         if (w_elig_oh[i]) begin
            w_sel_op  = r_op[i];
            w_sel_tag = r_tag[i];
            w_sel_v   = {r_v[i][1], r_v[i][0]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
         r_op   <= '0;
         r_tag  <= '0;
         r_rdy  <= '0;
         r_q    <= '0;
         r_v    <= '0;
      end else begin
         for (int i = 0; i < N_ENTRY; i++) begin
            for (int k = 0; k < 2; k++) begin
               if (r_busy[i] && !r_rdy[i][k] && bus.i_cdb_valid && (r_q[i][k] == bus.i_cdb_tag)) begin
                  r_rdy[i][k] <= 1'b1;
                  r_v[i][k]   <= bus.i_cdb_wdata;
               end
            end
            if (w_load && w_elig_oh[i]) begin
               r_busy[i] <= 1'b0;
            end
            // Only a free entry is ever written, so this never collides with wakeup or issue.
            if (w_dsp_fire && w_free_oh[i]) begin
               r_busy[i] <= 1'b1;
               r_op[i]   <= bus.i_dsp_opcode;
               r_tag[i]  <= bus.i_dsp_tag;
               r_rdy[i]  <= w_dsp_rdy;
               r_q[i]    <= w_dsp_q;
               r_v[i]    <= w_dsp_v;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_valid <= 1'b0;
         r_alu_op    <= '0;
         r_alu_tag   <= '0;
         r_alu_v     <= '0;
      end else if (w_load) begin
         r_alu_valid <= 1'b1;
         r_alu_op    <= w_sel_op;
         r_alu_tag   <= w_sel_tag;
         r_alu_v     <= w_sel_v;
      end else if (bus.o_alu_ready) begin
         r_alu_valid <= 1'b0;
      end
   end

   assign bus.i_dsp_ready     = |w_free;
   assign bus.o_alu_valid     = r_alu_valid;
   assign bus.o_alu_opcode    = r_alu_op;
   assign bus.o_alu_tag       = r_alu_tag;
   assign bus.o_alu_V_flatten = r_alu_v;
endmodule
